seq_tx: RTL and testbench
=========================

SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 Parameter: DATA_W, default 8, payload bits per frame (legal range 2..32).
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  request to start a frame; accepted only when ready=1.
REQ-005 Port: data  input  DATA_W  payload; sampled only in the acceptance cycle.
REQ-006 Port: ready  output  1  high when a load will be accepted.
REQ-007 Port: x  output  1  registered serial bit stream.
REQ-008 Port: busy  output  1  high while a frame is being driven on x.
REQ-009 Port: done  output  1  single-cycle pulse marking the final bit of a frame.
REQ-010 The block SHALL use one clock; reset SHALL be synchronous and active-high, named clock and reset.

Function
REQ-011 The FSM SHALL have the states IDLE, SYNC, DATA, PAR (PAR exists only per REQ-026), and all outputs SHALL be registered.
REQ-012 In IDLE: x=0, busy=0, done=0, ready=1.
REQ-013 The block SHALL accept a frame on any rising edge with load=1 and ready=1 (cycle t), and SHALL capture data into an internal shift register at that edge.
REQ-014 Changes on data after acceptance SHALL NOT affect the frame in flight.
REQ-015 The frame SHALL start in cycle t+1: SYNC drives the fixed preamble 1,0,0,1 on x for 4 cycles, MSB first.
REQ-016 After SYNC, DATA SHALL drive the captured payload MSB first for DATA_W cycles.
REQ-017 busy SHALL be 1 for every bit cycle of a frame and 0 otherwise.
REQ-018 In the final bit cycle of a frame (last DATA bit, or the PAR bit when enabled), done=1 and ready=1.
REQ-019 If load=1 in that final bit cycle, the next frame SHALL start with no idle gap: SYNC bit 1 in the following cycle.
REQ-020 If load=0 in the final bit cycle, the FSM SHALL return to IDLE (x=0).
REQ-021 While busy and not in the final bit cycle, ready=0 and load SHALL be ignored with no side effects.
REQ-022 The bit counter SHALL be sized to hold DATA_W-1 and SHALL reset to 0 on every state entry, with no wrap beyond the terminal count.
REQ-023 Frame length SHALL be 4+DATA_W cycles without parity and 5+DATA_W cycles with parity.

Reset
REQ-024 While reset=1: state=IDLE, x=0, busy=0, done=0, ready=1, shift register and counter cleared; reset SHALL take priority over load.
REQ-025 Reset asserted mid-frame SHALL abort the frame in the next cycle with no remaining bits emitted; a load in the reset cycle SHALL be discarded.

Configuration
REQ-026 Macro SEQ_TX_PARITY_EN: when defined, a PAR state SHALL follow DATA and drive one even-parity bit (XOR of the payload) for 1 cycle.
REQ-027 When SEQ_TX_PARITY_EN is defined, done and ready SHALL move to the PAR cycle.
REQ-028 When SEQ_TX_PARITY_EN is undefined, the PAR state and parity logic SHALL NOT be compiled in.

Verification
REQ-029 DATA_W=8, no parity, load with data=8'hA5 -> x = 1,0,0,1,1,0,1,0,0,1,0,1 over cycles t+1..t+12; done high only at t+12; then x=0 and ready=1.
REQ-030 SEQ_TX_PARITY_EN, data=8'hA5 -> same 12 bits, then x=0 at t+13 with done at t+13; data=8'h01 -> parity bit x=1.
REQ-031 load=1 with data=8'hFF at t+5 during a frame -> ignored; the original frame is unchanged and no second frame starts.
REQ-032 Back-to-back: loads of 8'h0F then 8'hF0, the second held during the done cycle -> 24 contiguous bits 1001_00001111_1001_11110000.
REQ-033 reset pulsed at t+6 of a frame -> x=0, busy=0, ready=1 from t+7; no further frame bits emitted.
REQ-034 Loopback into the team's 1001 Mealy detector -> detector z=1 in the 4th SYNC bit cycle of every frame.

Source files
------------

// File: rtl/seq_tx.sv
// Serial frame transmitter: 1,0,0,1 preamble followed by DATA_W payload bits, MSB first.
// Optional even-parity trailer bit when SEQ_TX_PARITY_EN is defined.
module seq_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              x,
    output logic              busy,
    output logic              done
);

    // The counter must reach both DATA_W-1 and the last preamble index (3).
    localparam int CNT_W = ($clog2(DATA_W) < 2) ? 2 : $clog2(DATA_W);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
`ifndef SEQ_TX_PARITY_EN
    localparam logic [CNT_W-1:0] DATA_PENULT = CNT_W'(DATA_W - 2);
`endif

`ifdef SEQ_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
`ifdef SEQ_TX_PARITY_EN
    logic              par_q;
`endif

    // ready is registered high exactly in IDLE and in the final bit of a frame.
    logic accept;
    assign accept = load && ready;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
            x     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ready <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else if (accept) begin
            state <= SYNC;
            cnt   <= '0;
            shreg <= data;
            x     <= 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
            ready <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q <= ^data;
`endif
        end else begin
            case (state)
                SYNC: begin
                    if (cnt == SYNC_LAST) begin
                        state <= DATA;
                        cnt   <= '0;
                        x     <= shreg[DATA_W-1];
                        shreg <= {shreg[DATA_W-2:0], 1'b0};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        // Preamble after its leading 1 is 0,0,1: only the step from index 2 emits a 1.
                        x   <= (cnt == CNT_W'(2));
                    end
                end
                DATA: begin
                    if (cnt == DATA_LAST) begin
`ifdef SEQ_TX_PARITY_EN
                        state <= PAR;
                        cnt   <= '0;
                        x     <= par_q;
                        done  <= 1'b1;
                        ready <= 1'b1;
`else
                        state <= IDLE;
                        cnt   <= '0;
                        x     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                        ready <= 1'b1;
`endif
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        x     <= shreg[DATA_W-1];
                        shreg <= {shreg[DATA_W-2:0], 1'b0};
`ifndef SEQ_TX_PARITY_EN
                        if (cnt == DATA_PENULT) begin
                            done  <= 1'b1;
                            ready <= 1'b1;
                        end
`endif
                    end
                end
`ifdef SEQ_TX_PARITY_EN
                PAR: begin
                    state <= IDLE;
                    cnt   <= '0;
                    x     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx.sv
// Table-driven, scoreboard-checked bench for seq_tx (DATA_W=8), including a
// model of a 1001 Mealy detector fed from x.
module tb_seq_tx;

    localparam int DATA_W = 8;
`ifdef SEQ_TX_PARITY_EN
    localparam int FRAME_LEN = 13;
`else
    localparam int FRAME_LEN = 12;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              load;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              x;
    logic              busy;
    logic              done;

    seq_tx #(.DATA_W(DATA_W)) dut (
        .clock(clock),
        .reset(reset),
        .load (load),
        .data (data),
        .ready(ready),
        .x    (x),
        .busy (busy),
        .done (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic busy;
        logic done;
        logic ready;
        logic x;
    } obs_t;

    typedef struct {
        obs_t obs;
        bit   sync4;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] bits;
        logic        par;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[6];
    vec_t       v0f;
    vec_t       vf0;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] det_hist;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input vec_t v);
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            e.obs.x     = v.bits[11-i];
            e.obs.busy  = 1'b1;
            e.obs.done  = (i == FRAME_LEN - 1);
            e.obs.ready = (i == FRAME_LEN - 1);
            e.sync4     = (i == 3);
            sb.push_back(e);
        end
`ifdef SEQ_TX_PARITY_EN
        e.obs.x     = v.par;
        e.obs.busy  = 1'b1;
        e.obs.done  = 1'b1;
        e.obs.ready = 1'b1;
        e.sync4     = 1'b0;
        sb.push_back(e);
`endif
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e.obs.x     = 1'b0;
        e.obs.busy  = 1'b0;
        e.obs.done  = 1'b0;
        e.obs.ready = 1'b1;
        e.sync4     = 1'b0;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    // Pop one expected cycle, compare outputs, and run the loopback detector.
    task automatic check_cycle(input string tag);
        exp_t e;
        logic z;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard underflow", tag);
            return;
        end
        e = sb.pop_front();
        check(tag, 32'({busy, done, ready, x}), 32'(e.obs));
        z = (det_hist == 3'b100) && x;
        if (e.sync4) check({tag, "_det_z"}, 32'(z), 32'd1);
        det_hist = {det_hist[1:0], x};
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) begin
            check_cycle(tag);
            data = 8'($urandom);
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 12'b1001_1010_0101, 1'b0};
        vecs[1] = '{8'h01, 12'b1001_0000_0001, 1'b1};
        vecs[2] = '{8'h00, 12'b1001_0000_0000, 1'b0};
        vecs[3] = '{8'hFF, 12'b1001_1111_1111, 1'b0};
        vecs[4] = '{8'h80, 12'b1001_1000_0000, 1'b1};
        vecs[5] = '{8'h3C, 12'b1001_0011_1100, 1'b0};
        v0f     = '{8'h0F, 12'b1001_0000_1111, 1'b0};
        vf0     = '{8'hF0, 12'b1001_1111_0000, 1'b0};
        det_hist = 3'b000;

        // Reset with load held high: reset wins.
        reset = 1'b1;
        load  = 1'b1;
        data  = 8'hFF;
        repeat (3) tick();
        check("reset_x",     32'(x),     32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        check("reset_done",  32'(done),  32'd0);
        check("reset_ready", 32'(ready), 32'd1);
        reset = 1'b0;
        load  = 1'b0;
        push_idle(2);
        drain("idle");

        // Table of single frames; data is scrambled after acceptance.
        foreach (vecs[i]) begin
            data = vecs[i].data;
            load = 1'b1;
            tick();
            load = 1'b0;
            push_frame(vecs[i]);
            push_idle(2);
            drain($sformatf("vec%0d", i));
        end

        // Load during a frame (t+5) is ignored.
        data = 8'hA5;
        load = 1'b1;
        tick();
        load = 1'b0;
        push_frame(vecs[0]);
        push_idle(3);
        for (int k = 1; sb.size() > 0; k++) begin
            check_cycle("ignore");
            load = (k == 5);
            data = (k == 5) ? 8'hFF : 8'h00;
            tick();
        end

        // Back-to-back: second load held in the done cycle.
        data = 8'h0F;
        load = 1'b1;
        tick();
        load = 1'b0;
        data = 8'h00;
        push_frame(v0f);
        push_frame(vf0);
        push_idle(2);
        for (int k = 1; sb.size() > 0; k++) begin
            check_cycle("b2b");
            load = (k == FRAME_LEN);
            data = (k == FRAME_LEN) ? 8'hF0 : 8'h00;
            tick();
        end

        // Reset at t+6 aborts the frame; the load in the reset cycle is discarded.
        data = 8'hA5;
        load = 1'b1;
        tick();
        load = 1'b0;
        push_frame(vecs[0]);
        for (int k = 1; k <= 6; k++) begin
            check_cycle("rst_mid");
            if (k == 6) begin
                reset = 1'b1;
                load  = 1'b1;
                data  = 8'hFF;
            end
            tick();
        end
        reset = 1'b0;
        load  = 1'b0;
        sb.delete();
        push_idle(4);
        drain("rst_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
